// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared stall-vector indices, stall patterns and FSM encodings.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_WB    = 4;

  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_IF   = 5'b00001;
  localparam logic [4:0] STALL_ID   = 5'b00011;
  localparam logic [4:0] STALL_MEM  = 5'b01111;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_WAIT_FETCH = 1'b1
  } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : stall_watchdog
// Brief   : Saturating PC-stall statistics and sticky consecutive-stall alarm.
// Revision: 1.0 - initial release
// ============================================================================
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int STALL_TO = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  localparam int               RUN_W      = $clog2(STALL_TO + 1);
  localparam logic [RUN_W-1:0] c_run_max  = RUN_W'(STALL_TO);
  localparam logic [RUN_W-1:0] c_run_trip = RUN_W'(STALL_TO - 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_stall_cnt <= '0;
      r_run_cnt   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (stall_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (!stall_pc) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != c_run_max) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
      // Trip on the edge where the run count reaches the limit.
      if (stall_pc && (r_run_cnt >= c_run_trip)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign stall_cnt     = r_stall_cnt;
  assign stall_timeout = r_timeout;

endmodule : stall_watchdog
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl
// Brief   : 5-stage pipeline stall/flush/redirect sequencer with stall watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 32,
  parameter int STALL_TO = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_mem,
  input  logic              ex_branch,
  input  logic [ADDR_W-1:0] ex_target,
  output logic [4:0]        stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_timeout
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pend_pc;
  logic              w_eff_br;

  // EX is frozen behind a MEM stall, so a branch only counts once MEM releases.
  assign w_eff_br = ex_branch & ~stallreq_mem;

  always_comb begin
    stall       = STALL_NONE;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    if (rst != RstEnable) begin
      case (r_state)
        ST_WAIT_FETCH: begin
          redirect_pc = r_pend_pc;
          if (stallreq_mem)     stall = STALL_MEM;
          else if (stallreq_if) stall = STALL_IF;
          if (!stallreq_if && !stallreq_mem) begin
            flush_if_id = 1'b1;
            redirect    = 1'b1;
          end
        end
        default: begin
          redirect_pc = ex_target;
          if (stallreq_mem)                   stall = STALL_MEM;
          else if (stallreq_id && !w_eff_br)  stall = STALL_ID;
          else if (stallreq_if)               stall = STALL_IF;
          if (w_eff_br) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            redirect    = ~stallreq_if;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state   <= ST_IDLE;
      r_pend_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Fetch still in flight: park the target until it returns.
          if (w_eff_br && stallreq_if) begin
            r_pend_pc <= ex_target;
            r_state   <= ST_WAIT_FETCH;
          end
        end
        ST_WAIT_FETCH: begin
          if (!stallreq_if && !stallreq_mem) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  stall_watchdog #(
    .CNT_W    (CNT_W),
    .STALL_TO (STALL_TO)
  ) u_stall_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (stall[STALL_PC]),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_ctrl
// Brief   : Directed and randomized self-checking bench for pipe_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int AW = 32;
  localparam int CW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_mem = 1'b0;
  logic          ex_branch = 1'b0;
  logic [AW-1:0] ex_target = '0;
  logic [4:0]    stall;
  logic          flush_if_id, flush_id_ex, redirect, stall_timeout;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl #(.ADDR_W(AW), .CNT_W(CW), .STALL_TO(TO)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
    .ex_branch(ex_branch), .ex_target(ex_target),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: a pending-redirect slot plus plain integer counters.
  bit            m_pending = 1'b0;
  logic [AW-1:0] m_pend_pc = '0;
  int            m_cnt = 0, m_run = 0;
  bit            m_to = 1'b0;
  logic [4:0]    e_stall;
  logic          e_fi, e_fe, e_red;
  logic [AW-1:0] e_rpc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_pending = 1'b0; m_pend_pc = '0; m_cnt = 0; m_run = 0; m_to = 1'b0;
  endtask

  task automatic model_outputs();
    e_stall = 5'b00000; e_fi = 0; e_fe = 0; e_red = 0; e_rpc = '0;
    if (rst) begin
      if (m_pending) begin
        e_rpc = m_pend_pc;
        if (stallreq_mem)     e_stall = 5'b01111;
        else if (stallreq_if) e_stall = 5'b00001;
        if (!stallreq_if && !stallreq_mem) begin e_fi = 1; e_red = 1; end
      end else begin
        e_rpc = ex_target;
        if (stallreq_mem)                     e_stall = 5'b01111;
        else if (stallreq_id && !ex_branch)   e_stall = 5'b00011;
        else if (stallreq_if)                 e_stall = 5'b00001;
        if (ex_branch && !stallreq_mem) begin
          e_fi = 1; e_fe = 1; e_red = !stallreq_if;
        end
      end
    end
  endtask

  task automatic check_all();
    model_outputs();
    chk("stall",         64'(stall),         64'(e_stall));
    chk("flush_if_id",   64'(flush_if_id),   64'(e_fi));
    chk("flush_id_ex",   64'(flush_id_ex),   64'(e_fe));
    chk("redirect",      64'(redirect),      64'(e_red));
    chk("redirect_pc",   64'(redirect_pc),   64'(e_rpc));
    chk("stall_cnt",     64'(stall_cnt),     64'(m_cnt));
    chk("stall_timeout", 64'(stall_timeout), 64'(m_to));
  endtask

  task automatic model_advance();
    if (!rst) begin
      model_clear();
    end else begin
      if (e_stall[0]) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_run < TO) m_run++;
        if (m_run == TO) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
      if (m_pending) begin
        if (!stallreq_if && !stallreq_mem) m_pending = 1'b0;
      end else if (ex_branch && !stallreq_mem && stallreq_if) begin
        m_pending = 1'b1;
        m_pend_pc = ex_target;
      end
    end
  endtask

  // One clock cycle: drive, settle, compare, then advance model past the edge.
  task automatic step(input bit a_if, input bit a_id, input bit a_mem,
                      input bit a_br, input logic [AW-1:0] a_tgt);
    stallreq_if = a_if; stallreq_id = a_id; stallreq_mem = a_mem;
    ex_branch = a_br; ex_target = a_tgt;
    assert (!(m_pending && a_br)) else $fatal(1, "FAIL stimulus branch-in-wait-fetch");
    #2;
    check_all();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    check_all();
    chk("pend_pc_rst", 64'(dut.r_pend_pc), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bit            hold = 0;
    logic [AW-1:0] hold_tgt = '0;
    bit            r_if, r_id, r_mem, r_br;
    logic [AW-1:0] r_tgt;

    // Reset with MEM stall requested
    step(0, 0, 1, 0, 32'h0);
    rst = 1'b1;
    step(0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    chk("cnt_after_one", 64'(stall_cnt), 64'd1);

    // Load-use coincides with a taken branch
    stallreq_id = 1; ex_branch = 1; ex_target = 32'h100; #2;
    chk("id_br_stall", 64'(stall), 64'd0);
    chk("id_br_redir", 64'(redirect), 64'd1);
    chk("id_br_pc",    64'(redirect_pc), 64'h100);
    step(0, 1, 0, 1, 32'h100);

    // Branch during in-flight fetch
    step(1, 0, 0, 1, 32'h200);
    repeat (3) step(1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h55);

    // Same, but MEM stalls on the fetch-return cycle
    step(1, 0, 0, 1, 32'h200);
    repeat (3) step(1, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);
    stallreq_mem = 0; stallreq_id = 0; #2;
    chk("late_redir",    64'(redirect), 64'd1);
    chk("late_redir_pc", 64'(redirect_pc), 64'h200);
    step(0, 0, 0, 0, 32'h0);

    // Branch held behind MEM stall
    repeat (2) step(0, 0, 1, 1, 32'h300);
    step(0, 0, 0, 1, 32'h300);
    step(0, 0, 0, 0, 32'h0);

    // Watchdog: 3-cycle burst, gap, 4-cycle burst
    do_reset();
    repeat (3) step(1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    repeat (4) step(1, 0, 0, 0, 32'h0);
    stallreq_if = 0; #2;
    chk("timeout_set", 64'(stall_timeout), 64'd1);
    step(1, 0, 0, 1, 32'h400);
    step(1, 0, 0, 0, 32'h0);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
        hold = 0;
      end
      r_mem = ($urandom_range(4) == 0);
      r_if  = ($urandom_range(2) == 0);
      r_id  = ($urandom_range(3) == 0);
      if (hold) begin
        r_br = 1; r_tgt = hold_tgt;
      end else begin
        r_br  = !m_pending && ($urandom_range(3) == 0);
        r_tgt = $urandom;
      end
      hold     = r_br && r_mem;
      hold_tgt = r_tgt;
      step(r_if, r_id, r_mem, r_br, r_tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_pipe_ctrl
`default_nettype wire
